// File: rtl/dist_sq_seq_if.sv
// Request/result bundle between a pixel source and the squared-distance unit.
interface dist_sq_seq_if #(
    parameter int COORD_WIDTH = 10,
    parameter int OUT_WIDTH   = 12
);
    // Level handshake: start is sampled only while finish=1 (idle).
    // A sampled start drops finish on the next edge; finish returning high
    // marks dist_sq valid, and it stays valid until the next accepted start.
    logic                   start;
    logic [COORD_WIDTH-1:0] px;
    logic [COORD_WIDTH-1:0] py;
    logic [COORD_WIDTH-1:0] cx;
    logic [COORD_WIDTH-1:0] cy;
    logic [OUT_WIDTH-1:0]   dist_sq;
    logic                   finish;

    modport master (
        output start, px, py, cx, cy,
        input  dist_sq, finish
    );

    modport slave (
        input  start, px, py, cx, cy,
        output dist_sq, finish
    );
endinterface

// File: rtl/dist_sq_seq.sv
// Shift-add squared distance (px-cx)^2 + (py-cy)^2, scaled by SHIFT and saturated.
// Optional round-half-up scaling is enabled by defining DIST_SQ_ROUND_EN.
module dist_sq_seq #(
    parameter int COORD_WIDTH = 10,
    parameter int OUT_WIDTH   = 12,
    parameter int SHIFT       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    dist_sq_seq_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int ACC_W = 2 * COORD_WIDTH + 1;
    localparam int CNT_W = $clog2(COORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_X = 2'd1,
        MUL_Y = 2'd2,
        NORM  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [COORD_WIDTH-1:0] mcand;
    logic [COORD_WIDTH-1:0] mcand_next;
    logic [COORD_WIDTH-1:0] mplier;
    logic [COORD_WIDTH-1:0] mplier_next;
    logic [COORD_WIDTH-1:0] b_hold;
    logic [COORD_WIDTH-1:0] b_hold_next;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_next;
    logic [OUT_WIDTH-1:0]   dist_q;
    logic [OUT_WIDTH-1:0]   dist_next;
    logic                   finish_q;
    logic                   finish_next;

    logic [COORD_WIDTH-1:0] diff_x;
    logic [COORD_WIDTH-1:0] diff_y;
    logic [ACC_W-1:0]       addend;
    logic [ACC_W:0]         scaled;
    logic [OUT_WIDTH-1:0]   sat;

    // Larger minus smaller keeps the magnitude unsigned and COORD_WIDTH wide.
    assign diff_x = (bus.px >= bus.cx) ? (bus.px - bus.cx) : (bus.cx - bus.px);
    assign diff_y = (bus.py >= bus.cy) ? (bus.py - bus.cy) : (bus.cy - bus.py);

    assign addend = ACC_W'(mcand) << count;

`ifdef DIST_SQ_ROUND_EN
    localparam int RND_POS = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic [ACC_W:0] RND_BIAS = (SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;
    assign scaled = ({1'b0, acc} + RND_BIAS) >> SHIFT;
`else
    assign scaled = {1'b0, acc} >> SHIFT;
`endif

    assign sat = ((scaled >> OUT_WIDTH) != '0) ? '1 : scaled[OUT_WIDTH-1:0];

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        b_hold_next = b_hold;
        count_next  = count;
        acc_next    = acc;
        dist_next   = dist_q;
        finish_next = finish_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    mcand_next  = diff_x;
                    mplier_next = diff_x;
                    b_hold_next = diff_y;
                    acc_next    = '0;
                    count_next  = '0;
                    finish_next = 1'b0;
                    state_next  = MUL_X;
                end
            end
            MUL_X, MUL_Y: begin
                if (mplier[0]) begin
                    acc_next = acc + addend;
                end
                mplier_next = mplier >> 1;
                count_next  = count + CNT_W'(1);
                if (count == CNT_LAST) begin
                    count_next = '0;
                    // b^2 accumulates on top of a^2 in the same register.
                    if (state == MUL_X) begin
                        mcand_next  = b_hold;
                        mplier_next = b_hold;
                        state_next  = MUL_Y;
                    end else begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                dist_next   = sat;
                finish_next = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            b_hold   <= '0;
            count    <= '0;
            acc      <= '0;
            dist_q   <= '0;
            finish_q <= 1'b1;
        end else begin
            state    <= state_next;
            mcand    <= mcand_next;
            mplier   <= mplier_next;
            b_hold   <= b_hold_next;
            count    <= count_next;
            acc      <= acc_next;
            dist_q   <= dist_next;
            finish_q <= finish_next;
        end
    end

    assign bus.dist_sq = dist_q;
    assign bus.finish  = finish_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_dist_sq_seq.sv
// Scoreboard bench for dist_sq_seq: driver pushes model results, monitor checks on finish rise.
module tb_dist_sq_seq;
    localparam int CW      = 10;
    localparam int OW      = 12;
    localparam int SH      = 8;
    localparam int LATENCY = 2 * CW + 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    dist_sq_seq_if #(.COORD_WIDTH(CW), .OUT_WIDTH(OW)) sif ();

    dist_sq_seq #(.COORD_WIDTH(CW), .OUT_WIDTH(OW), .SHIFT(SH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (sif),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [OW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [OW-1:0] last_result = '0;
    logic [1:0]    idle_code = '0;
    logic          prev_fin = 1'b1;
    int            busy_cnt = 0;
    int            idle_run = 0;
    logic          b2b_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the definition of the result.
    function automatic logic [OW-1:0] model(input int px, input int py, input int cx, input int cy);
        longint dx;
        longint dy;
        longint s;
        dx = px - cx;
        dy = py - cy;
        s  = dx * dx + dy * dy;
`ifdef DIST_SQ_ROUND_EN
        if (SH > 0) s = s + (64'sd1 <<< (SH - 1));
`endif
        s = s / (64'sd1 <<< SH);
        if (s > (64'sd1 <<< OW) - 1) return '1;
        return s[OW-1:0];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_fin    = 1'b1;
            busy_cnt    = 0;
            idle_run    = 0;
            last_result = '0;
        end else if (!sif.finish) begin
            if (prev_fin && b2b_mode) check("b2b_idle_cycles", idle_run, 1);
            busy_cnt++;
            check("hold_while_busy", sif.dist_sq, last_result);
            checks++;
            if (dbg_state === idle_code) begin
                errors++;
                $display("FAIL busy_state: got %0d expected not %0d", dbg_state, idle_code);
            end
            prev_fin = 1'b0;
        end else begin
            if (!prev_fin) begin
                check("latency", busy_cnt, LATENCY);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none", sif.dist_sq);
                end else begin
                    last_result = exp_q.pop_front();
                    check("dist_sq", sif.dist_sq, last_result);
                end
                busy_cnt = 0;
                idle_run = 1;
            end else begin
                idle_run++;
            end
            prev_fin = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_coords();
        sif.px = CW'($urandom_range(0, (1 << CW) - 1));
        sif.py = CW'($urandom_range(0, (1 << CW) - 1));
        sif.cx = CW'($urandom_range(0, (1 << CW) - 1));
        sif.cy = CW'($urandom_range(0, (1 << CW) - 1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!sif.finish && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sif.finish) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got finish=%0d expected 1", sif.finish);
        end
    endtask

    task automatic issue_op(input int px, input int py, input int cx, input int cy);
        wait_idle();
        sif.px    = CW'(px);
        sif.py    = CW'(py);
        sif.cx    = CW'(cx);
        sif.cy    = CW'(cy);
        sif.start = 1'b1;
        exp_q.push_back(model(px, py, cx, cy));
        @(posedge clk); #1;
        sif.start = 1'b0;
        randomize_coords();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_ops;
        int guard;
        rst_n     = 1'b0;
        sif.start = 1'b0;
        sif.px    = '0;
        sif.py    = '0;
        sif.cx    = '0;
        sif.cy    = '0;

        @(posedge clk); #1;
        check("reset_finish", sif.finish, 1);
        check("reset_dist_sq", sif.dist_sq, 0);
        idle_code = dbg_state;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue_op(400, 300, 320, 240);
        issue_op(0, 0, 1023, 1023);
        issue_op(5, 5, 5, 5);
        issue_op(12, 0, 0, 0);
        issue_op(0, 1023, 0, 0);
        issue_op(1023, 0, 0, 1023);

        // Random operations with random idle gaps
        for (int i = 0; i < 30; i++) begin
            issue_op(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                     int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        @(posedge clk); #1;

        // start held high, coordinates changing every cycle
        n_ops = 0;
        guard = 0;
        sif.start = 1'b1;
        while (n_ops < 4 && guard < 400) begin
            randomize_coords();
            if (sif.finish) begin
                if (n_ops >= 1) b2b_mode = 1'b1;
                exp_q.push_back(model(int'(sif.px), int'(sif.py), int'(sif.cx), int'(sif.cy)));
                n_ops++;
            end
            @(posedge clk); #1;
            guard++;
        end
        sif.start = 1'b0;
        check("held_start_ops", n_ops, 4);
        wait_idle();
        @(posedge clk); #1;
        b2b_mode = 1'b0;

        // Reset in the 7th busy cycle abandons the operation
        issue_op(1023, 1023, 0, 0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("midop_reset_finish", sif.finish, 1);
        check("midop_reset_dist_sq", sif.dist_sq, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue_op(400, 300, 320, 240);

        // Drain the scoreboard
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
